axis_capture_mem: RTL and testbench

AXIS_CAPTURE_MEM -- requirements
Module: axis_capture_mem

---
 rtl/axis_capture_mem_pkg.sv | 21 ++
 rtl/axis_capture_mem_capture_ram.sv | 22 ++
 rtl/axis_capture_mem.sv | 132 +++++++++++++
 tb/tb_axis_capture_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_capture_mem_pkg.sv
// Shared constants for the AXIS capture memory: FSM encoding, APB register
// offsets, default geometry and the STATUS word layout.
package axis_capture_mem_pkg;

   localparam logic [15:0] BASE_HI_DEF     = 16'h43C1;
   localparam int          DEPTH_WORDS_DEF = 1024;
   localparam int          NUM_LANES       = 4;

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_RECV = 2'd1;
   localparam logic [1:0]  ST_DONE = 2'd2;

   localparam logic [12:0] OFS_STATUS = 13'h1000;
   localparam logic [12:0] OFS_CTRL   = 13'h1004;

   function automatic logic [31:0] status_word(input logic ovf, input logic done,
                                               input logic [11:0] len);
      return {18'd0, ovf, done, len};
   endfunction

endpackage

// File: rtl/axis_capture_mem_capture_ram.sv
// 1-write / 1-read synchronous RAM; a read of the word being written in the
// same cycle returns the previous contents. Contents are never reset.
module capture_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/axis_capture_mem.sv
// Captures a byte-wide AXI-Stream frame into a word memory and exposes the
// memory plus STATUS/CTRL registers on APB.
module axis_capture_mem
   import axis_capture_mem_pkg::*;
#(
   parameter logic [15:0] BASE_HI     = BASE_HI_DEF,
   parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF
) (
   input  logic        S_APB_aclk,
   input  logic        S_APB_aresetn,
   input  logic [31:0] S_APB_paddr,
   input  logic        S_APB_psel,
   input  logic        S_APB_penable,
   input  logic        S_APB_pwrite,
   input  logic [31:0] S_APB_pwdata,
   output logic [31:0] S_APB_prdata,
   output logic        S_APB_pready,
   output logic        S_APB_pslverr,
   input  logic [7:0]  S_AXIS_tdata,
   input  logic        S_AXIS_tvalid,
   input  logic        S_AXIS_tkeep,
   input  logic        S_AXIS_tlast,
   output logic        S_AXIS_tready,
   output logic        Rcv_Done,
   output logic [11:0] Rcv_Length,
   output logic        Rcv_Overflow
);

   localparam int          AW  = $clog2(DEPTH_WORDS);
   localparam logic [12:0] CAP = 13'(DEPTH_WORDS * NUM_LANES);

   logic [1:0]                  state;
   logic [12:0]                 byte_cnt, cnt_nxt;
   logic [NUM_LANES-1:0][7:0]   hold, hold_nxt;
   logic [1:0]                  lane;
   logic                        beat, full, store, wr_en, clr;
   logic [11:0]                 len_last;
   logic                        apb_acc, hit;
   logic [AW-1:0]               wr_addr, rd_addr;
   logic [31:0]                 rd_data, rd_mux;

   // ---------------- stream side ----------------
   assign S_AXIS_tready = (state != ST_DONE);
   assign beat          = S_AXIS_tvalid && S_AXIS_tready && !clr;
   assign full          = (byte_cnt == CAP);
   assign store         = beat && S_AXIS_tkeep && !full;
   assign lane          = byte_cnt[1:0];
   assign wr_addr       = byte_cnt[AW+1:2];
   assign cnt_nxt       = byte_cnt + {12'd0, store};
   assign len_last      = (cnt_nxt == 13'd0) ? 12'd0 : 12'(cnt_nxt - 13'd1);

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign hold_nxt[g] = (store && lane == 2'(g)) ? S_AXIS_tdata : hold[g];
   end

   // Flush a full word, or a partial one when the frame ends mid-word; lanes
   // not yet filled are still zero from the previous flush/clear.
   assign wr_en = store ? (lane == 2'd3 || S_AXIS_tlast)
                        : (beat && S_AXIS_tlast && lane != 2'd0);

   always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
      if (!S_APB_aresetn) begin
         state        <= ST_IDLE;
         byte_cnt     <= '0;
         hold         <= '0;
         Rcv_Done     <= 1'b0;
         Rcv_Overflow <= 1'b0;
         Rcv_Length   <= '0;
      end else if (clr) begin
         state        <= ST_IDLE;
         byte_cnt     <= '0;
         hold         <= '0;
         Rcv_Done     <= 1'b0;
         Rcv_Overflow <= 1'b0;
         Rcv_Length   <= '0;
      end else if (beat) begin
         byte_cnt <= cnt_nxt;
         hold     <= wr_en ? '0 : hold_nxt;
         if (S_AXIS_tkeep && full) Rcv_Overflow <= 1'b1;
         if (S_AXIS_tlast) begin
            state      <= ST_DONE;
            Rcv_Done   <= 1'b1;
            Rcv_Length <= len_last;
         end else begin
            state <= ST_RECV;
         end
      end
   end

   // ---------------- APB side ----------------
   assign S_APB_pslverr = 1'b0;
   assign apb_acc = S_APB_psel && S_APB_penable && !S_APB_pready;
   assign hit     = (S_APB_paddr[31:16] == BASE_HI);
   assign clr     = apb_acc && S_APB_pwrite && hit &&
                    (S_APB_paddr[12:0] == OFS_CTRL) && S_APB_pwdata[0];
   // RAM is read every cycle; paddr is stable from the setup phase, so the
   // word is ready by the first access cycle.
   assign rd_addr = S_APB_paddr[AW+1:2];

   always_comb begin
      rd_mux = '0;
      if (hit && !S_APB_pwrite) begin
         if (!S_APB_paddr[12])
            rd_mux = rd_data;
         else if (S_APB_paddr[12:0] == OFS_STATUS)
            rd_mux = status_word(Rcv_Overflow, Rcv_Done, Rcv_Length);
      end
   end

   always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
      if (!S_APB_aresetn) begin
         S_APB_pready <= 1'b0;
         S_APB_prdata <= '0;
      end else begin
         S_APB_pready <= apb_acc;
         if (apb_acc) S_APB_prdata <= rd_mux;
      end
   end

   capture_ram #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
      .clk   (S_APB_aclk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (hold_nxt),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   logic unused_apb;
   assign unused_apb = &{1'b0, S_APB_paddr[15:13], S_APB_paddr[1:0], S_APB_pwdata[31:1]};

endmodule

// File: tb/tb_axis_capture_mem.sv
// Directed bench: APB reads push expected data into a scoreboard queue that a
// monitor drains on every read-data handshake.
module tb_axis_capture_mem;

   localparam logic [31:0] BASE = 32'h43C1_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] paddr = '0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [7:0]  tdata = '0;
   logic        tvalid = 1'b0, tkeep = 1'b0, tlast = 1'b0;
   logic        tready;
   logic        rcv_done, rcv_ovf;
   logic [11:0] rcv_len;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   axis_capture_mem dut (
      .S_APB_aclk    (clk),
      .S_APB_aresetn (rst_n),
      .S_APB_paddr   (paddr),
      .S_APB_psel    (psel),
      .S_APB_penable (penable),
      .S_APB_pwrite  (pwrite),
      .S_APB_pwdata  (pwdata),
      .S_APB_prdata  (prdata),
      .S_APB_pready  (pready),
      .S_APB_pslverr (pslverr),
      .S_AXIS_tdata  (tdata),
      .S_AXIS_tvalid (tvalid),
      .S_AXIS_tkeep  (tkeep),
      .S_AXIS_tlast  (tlast),
      .S_AXIS_tready (tready),
      .Rcv_Done      (rcv_done),
      .Rcv_Length    (rcv_len),
      .Rcv_Overflow  (rcv_ovf)
   );

   // monitor: one pop per completed read
   always @(negedge clk) begin
      if (psel && penable && pready && !pwrite) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read got=%h", prdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (prdata !== e.exp) begin
               errors++;
               $display("FAIL %s got=%h exp=%h", e.name, prdata, e.exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   // all tasks start and end one time unit after a rising edge
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
      int n;
      psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
      @(posedge clk); #1 penable = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!pready && n < 8);
      if (!pready) begin
         checks++; errors++;
         $display("FAIL apb_timeout addr=%h", addr);
      end
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
      exp_t e;
      e.name = nm; e.exp = exp;
      sb.push_back(e);
      apb_xfer(addr, 1'b0, 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic k, input logic l);
      tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
      @(posedge clk); #1 tvalid = 1'b0; tkeep = 1'b0; tlast = 1'b0;
   endtask

   task automatic clear();
      apb_xfer(BASE + 32'h1004, 1'b1, 32'd1);
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      #23;
      // reset state
      chk("rst_done", {31'd0, rcv_done}, 32'd0);
      chk("rst_ovf", {31'd0, rcv_ovf}, 32'd0);
      chk("rst_len", {20'd0, rcv_len}, 32'd0);
      chk("rst_pready", {31'd0, pready}, 32'd0);
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("tready_idle", {31'd0, tready}, 32'd1);

      // basic 5-byte frame
      send_byte(8'h11, 1, 0); send_byte(8'h22, 1, 0); send_byte(8'h33, 1, 0);
      send_byte(8'h44, 1, 0); send_byte(8'h55, 1, 1);
      chk("len5", {20'd0, rcv_len}, 32'd4);
      apb_read(BASE + 32'h0, 32'h4433_2211, "f5_word0");
      apb_read(BASE + 32'h4, 32'h0000_0055, "f5_word1");
      apb_read(BASE + 32'h1000, 32'h0000_1004, "f5_status");

      // beat while DONE is refused
      tvalid = 1'b1; tdata = 8'h99; tkeep = 1'b1; tlast = 1'b0;
      @(negedge clk);
      chk("tready_done", {31'd0, tready}, 32'd0);
      @(posedge clk); #1 tvalid = 1'b0; tkeep = 1'b0;
      apb_read(BASE + 32'h4, 32'h0000_0055, "done_nowrite");
      apb_xfer(BASE + 32'h0, 1'b1, 32'hDEAD_BEEF);
      apb_read(BASE + 32'h0, 32'h4433_2211, "memwin_ro");
      apb_read(BASE + 32'h1008, 32'h0, "unmapped");
      apb_read(32'h43C2_0000, 32'h0, "not_selected");
      clear();
      apb_read(BASE + 32'h1000, 32'h0, "clr_status");
      chk("tready_clr", {31'd0, tready}, 32'd1);

      // tkeep=0 beats skipped, tlast on a non-kept beat flushes partial word
      send_byte(8'hAA, 1, 0); send_byte(8'hBB, 0, 0);
      send_byte(8'hCC, 1, 0); send_byte(8'hDD, 0, 1);
      apb_read(BASE + 32'h0, 32'h0000_CCAA, "keep_word0");
      apb_read(BASE + 32'h1000, 32'h0000_1001, "keep_status");
      clear();

      // empty frame: no write, length 0
      send_byte(8'hEE, 0, 1);
      apb_read(BASE + 32'h1000, 32'h0000_1000, "empty_status");
      apb_read(BASE + 32'h0, 32'h0000_CCAA, "empty_nowrite");
      clear();

      // 8-byte frame, Send_Length=7
      for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i), 1, i == 7);
      apb_read(BASE + 32'h0, 32'hA3A2_A1A0, "f8_word0");
      apb_read(BASE + 32'h4, 32'hA7A6_A5A4, "f8_word1");
      apb_read(BASE + 32'h1000, 32'h0000_1007, "f8_status");
      clear();

      // clear coincident with a tlast beat in RECV: beat discarded
      send_byte(8'h01, 1, 0); send_byte(8'h02, 1, 0); send_byte(8'h03, 1, 0);
      fork
         apb_xfer(BASE + 32'h1004, 1'b1, 32'd1);
         begin
            @(posedge clk); #1 tvalid = 1'b1; tdata = 8'hEE; tkeep = 1'b1; tlast = 1'b1;
            @(posedge clk); #1 tvalid = 1'b0; tkeep = 1'b0; tlast = 1'b0;
         end
      join
      apb_read(BASE + 32'h1000, 32'h0, "clrwin_status");
      send_byte(8'h5A, 1, 0); send_byte(8'h5B, 1, 1);
      apb_read(BASE + 32'h0, 32'h0000_5B5A, "clrwin_word0");
      apb_read(BASE + 32'h1000, 32'h0000_1001, "clrwin_status2");
      clear();

      // reset mid-frame
      send_byte(8'h71, 1, 0); send_byte(8'h72, 1, 0); send_byte(8'h73, 1, 0);
      rst_n = 1'b0;
      #2;
      chk("mrst_done", {31'd0, rcv_done}, 32'd0);
      chk("mrst_len", {20'd0, rcv_len}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mrst_tready", {31'd0, tready}, 32'd1);
      send_byte(8'h81, 1, 0); send_byte(8'h82, 1, 1);
      chk("mrst_len2", {20'd0, rcv_len}, 32'd1);
      apb_read(BASE + 32'h0, 32'h0000_8281, "mrst_word0");
      clear();

      // overflow: 4100 bytes, data = low byte of (i + i/256)
      for (int i = 0; i < 4100; i++) send_byte(8'(i + i / 256), 1, i == 4099);
      chk("ovf_flag", {31'd0, rcv_ovf}, 32'd1);
      chk("ovf_len", {20'd0, rcv_len}, 32'd4095);
      apb_read(BASE + 32'h1000, 32'h0000_3FFF, "ovf_status");
      apb_read(BASE + 32'h0, 32'h0302_0100, "ovf_word0");
      apb_read(BASE + 32'h4, 32'h0706_0504, "ovf_word1");
      apb_read(BASE + 32'hFFC, 32'h0E0D_0C0B, "ovf_word1023");

      repeat (4) @(posedge clk);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_leftover count=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
